// File: rtl/n_queen_solver.sv
// Parametrised N-queens backtracking engine with controller and datapath in one block.
// Each solution is streamed row by row over valid/ready, and emitted solutions are counted.
module n_queen_solver #(
  parameter int N  = 8,
  parameter int RW = (N > 1) ? $clog2(N) : 1,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_find_all,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_sol_valid,
  input  logic          i_sol_ready,
  output logic [N-1:0]  o_sol_data,
  output logic [RW-1:0] o_sol_row,
  output logic          o_sol_last,
  output logic [CW-1:0] o_solution_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_NEXT_COL  = 3'd2;
  localparam logic [2:0] S_BACKTRACK = 3'd3;
  localparam logic [2:0] S_EMIT      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  logic [2:0]    r_state;
  logic [N-1:0]  r_rows [N];
  logic [RW-1:0] r_r;
  logic [RW-1:0] r_k;
  logic          r_mode;
  logic [RW-1:0] r_sol_row;
  logic [CW-1:0] r_count;

  logic [N-1:0]  w_row_r;
  logic [N-1:0]  w_row_k;
  logic [RW-1:0] w_col_r;
  logic [RW-1:0] w_col_k;
  logic [RW:0]   w_rdist;
  logic [RW:0]   w_cdist;
  logic          w_conflict;
  logic [RW-1:0] w_r_inc;

  // Lowest set bit wins; only non-empty rows reach the comparator.
  function automatic logic [RW-1:0] f_col(input logic [N-1:0] onehot);
    logic [RW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (onehot[i]) idx = RW'(i);
    end
    return idx;
  endfunction

  assign w_row_r    = r_rows[r_r];
  assign w_row_k    = r_rows[r_k];
  assign w_col_r    = f_col(w_row_r);
  assign w_col_k    = f_col(w_row_k);
  assign w_rdist    = {1'b0, r_r} - {1'b0, r_k};
  assign w_cdist    = (w_col_r >= w_col_k) ? ({1'b0, w_col_r} - {1'b0, w_col_k})
                                           : ({1'b0, w_col_k} - {1'b0, w_col_r});
  assign w_conflict = (w_col_r == w_col_k) || (w_rdist == w_cdist);
  assign w_r_inc    = r_r + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < N; i++) r_rows[i] <= '0;
      r_r       <= '0;
      r_k       <= '0;
      r_mode    <= 1'b0;
      r_sol_row <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            for (int i = 0; i < N; i++) r_rows[i] <= '0;
            r_rows[0] <= N'(1);
            r_r       <= '0;
            r_k       <= '0;
            r_sol_row <= '0;
            r_count   <= '0;
            r_mode    <= i_find_all;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Row 0 is always safe; otherwise safe once row 0 has been checked clean.
          if ((r_r == '0) || (!w_conflict && (r_k == '0))) begin
            if (r_r == LAST_ROW) begin
              r_sol_row <= '0;
              r_state   <= S_EMIT;
            end else begin
              r_r             <= w_r_inc;
              r_rows[w_r_inc] <= N'(1);
              r_k             <= r_r;
            end
          end else if (w_conflict) begin
            r_state <= S_NEXT_COL;
          end else begin
            r_k <= r_k - 1'b1;
          end
        end
        S_NEXT_COL: begin
          if (w_row_r[N-1]) begin
            r_state <= S_BACKTRACK;
          end else begin
            r_rows[r_r] <= w_row_r << 1;
            r_k         <= (r_r == '0) ? '0 : (r_r - 1'b1);
            r_state     <= S_CHECK;
          end
        end
        S_BACKTRACK: begin
          r_rows[r_r] <= '0;
          if (r_r == '0) begin
            r_state <= S_DONE;
          end else begin
            r_r     <= r_r - 1'b1;
            r_state <= S_NEXT_COL;
          end
        end
        S_EMIT: begin
          if (i_sol_ready) begin
            if (r_sol_row == LAST_ROW) begin
              r_sol_row <= '0;
              if (r_count != '1) r_count <= r_count + 1'b1;
              // All-solutions mode resumes the search by advancing the last row.
              r_state   <= r_mode ? S_NEXT_COL : S_DONE;
            end else begin
              r_sol_row <= r_sol_row + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy           = (r_state == S_CHECK) || (r_state == S_NEXT_COL) ||
                            (r_state == S_BACKTRACK) || (r_state == S_EMIT);
  assign o_done           = (r_state == S_DONE);
  assign o_sol_valid      = (r_state == S_EMIT);
  assign o_sol_data       = o_sol_valid ? r_rows[r_sol_row] : '0;
  assign o_sol_row        = r_sol_row;
  assign o_sol_last       = o_sol_valid && (r_sol_row == LAST_ROW);
  assign o_solution_count = r_count;

endmodule

// File: tb/tb_n_queen_solver.sv
// Bench for n_queen_solver: five instances (N = 1, 3, 4, 6, 8) checked against a
// permutation-based reference model that lists solutions in lexicographic column order.
module tb_n_queen_solver;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  start;
  logic        find_all;
  logic        sol_ready;
  logic [4:0]  busy, done, valid, last;
  logic [15:0] data [5];
  logic [3:0]  row  [5];
  logic [15:0] cnt  [5];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model_sols [$];
  logic [15:0] cap_data   [$];
  logic [3:0]  cap_row    [$];
  logic        cap_last   [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int NS = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : (g == 3) ? 6 : 8;
    localparam int RS = (NS > 1) ? $clog2(NS) : 1;
    logic [NS-1:0] w_data;
    logic [RS-1:0] w_row;
    n_queen_solver #(.N(NS), .CW(16)) u_dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start[g]),
      .i_find_all       (find_all),
      .o_busy           (busy[g]),
      .o_done           (done[g]),
      .o_sol_valid      (valid[g]),
      .i_sol_ready      (sol_ready),
      .o_sol_data       (w_data),
      .o_sol_row        (w_row),
      .o_sol_last       (last[g]),
      .o_solution_count (cnt[g])
    );
    assign data[g] = 16'(w_data);
    assign row[g]  = 4'(w_row);
  end

  // Every N-queens solution is a permutation of columns; walk permutations in
  // lexicographic order and keep those with no shared diagonal.
  function automatic void build_model(input int n);
    int p [16];
    int i, j, t, lo, hi;
    logic ok;
    logic [63:0] s;
    model_sols.delete();
    for (int a = 0; a < 16; a++) p[a] = a;
    while (1) begin
      ok = 1'b1;
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++)
          if (((p[a] > p[b]) ? p[a] - p[b] : p[b] - p[a]) == b - a) ok = 1'b0;
      if (ok) begin
        s = '0;
        for (int a = 0; a < n; a++) s[a*4 +: 4] = 4'(p[a]);
        model_sols.push_back(s);
      end
      i = n - 2;
      while (i >= 0 && p[i] > p[i+1]) i--;
      if (i < 0) break;
      j = n - 1;
      while (p[j] < p[i]) j--;
      t = p[i]; p[i] = p[j]; p[j] = t;
      lo = i + 1; hi = n - 1;
      while (lo < hi) begin
        t = p[lo]; p[lo] = p[hi]; p[hi] = t;
        lo++; hi--;
      end
    end
  endfunction

  // Expected {data, row, last} for stream beat k of an N-wide board.
  function automatic logic [20:0] exp_beat(input int k, input int n);
    int s, r;
    logic [3:0] col;
    s   = k / n;
    r   = k % n;
    col = model_sols[s][r*4 +: 4];
    return {16'(1) << col, 4'(r), (r == n - 1)};
  endfunction

  task automatic do_start(input int idx, input logic fa);
    find_all   = fa;
    start[idx] = 1'b1;
    @(posedge clk); #1;
    start[idx] = 1'b0;
  endtask

  // Runs one instance to done, recording accepted beats and counting any beat that
  // changed while stalled.
  task automatic capture_run(input int idx, input bit rand_ready, input bit chaos_fa,
                             input int pulse_at, input int max_cycles,
                             output bit timed_out, output int stall_bad);
    logic pv, pr, pl;
    logic [15:0] pd;
    logic [3:0] prw;
    int cyc;
    cap_data.delete(); cap_row.delete(); cap_last.delete();
    timed_out = 1'b0; stall_bad = 0; pv = 1'b0; pr = 1'b1; pd = '0; prw = '0; pl = 1'b0;
    cyc = 0;
    while (!done[idx]) begin
      if (cyc >= max_cycles) begin
        timed_out = 1'b1;
        break;
      end
      if (pv && !pr && (!valid[idx] || data[idx] !== pd || row[idx] !== prw ||
                        last[idx] !== pl))
        stall_bad++;
      sol_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (chaos_fa) find_all = 1'($urandom_range(0, 1));
      start[idx] = (cyc == pulse_at);
      if (valid[idx] && sol_ready) begin
        cap_data.push_back(data[idx]);
        cap_row.push_back(row[idx]);
        cap_last.push_back(last[idx]);
      end
      pv = valid[idx]; pr = sol_ready; pd = data[idx]; prw = row[idx]; pl = last[idx];
      @(posedge clk); #1;
      cyc++;
    end
    start[idx] = 1'b0;
    sol_ready  = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({busy[i], done[i], valid[i], last[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_flags[%0d] got %b want 0000", i,
                 {busy[i], done[i], valid[i], last[i]});
      end
      n_checks++;
      if ({data[i], row[i]} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_data_row[%0d] got %h want 0", i, {data[i], row[i]});
      end
      n_checks++;
      if (cnt[i] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_count[%0d] got %0d want 0", i, cnt[i]);
      end
    end
  endtask

  task automatic test_n4_all();
    bit to;
    int sb;
    build_model(4);
    do_start(2, 1'b1);
    n_checks++;
    if ({busy[2], done[2]} !== 2'b10) begin
      n_fail++;
      $display("FAIL n4_busy_after_start got %b want 10", {busy[2], done[2]});
    end
    capture_run(2, 1'b0, 1'b0, -1, 5000, to, sb);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL n4_timeout got 1 want 0"); end
    n_checks++;
    if (cap_data.size() !== 8) begin
      n_fail++;
      $display("FAIL n4_beats got %0d want 8", cap_data.size());
    end
    for (int k = 0; k < cap_data.size() && k < model_sols.size() * 4; k++) begin
      n_checks++;
      if ({cap_data[k], cap_row[k], cap_last[k]} !== exp_beat(k, 4)) begin
        n_fail++;
        $display("FAIL n4_beat[%0d] got %h want %h", k, {cap_data[k], cap_row[k], cap_last[k]},
                 exp_beat(k, 4));
      end
    end
    n_checks++;
    if ({busy[2], done[2], cnt[2]} !== {2'b01, 16'd2}) begin
      n_fail++;
      $display("FAIL n4_final got busy/done=%b count=%0d want 01/2", {busy[2], done[2]}, cnt[2]);
    end
  endtask

  task automatic test_n8_first();
    bit to;
    int sb;
    logic [7:0] exp8 [8];
    exp8 = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
    do_start(4, 1'b0);
    capture_run(4, 1'b0, 1'b0, -1, 20000, to, sb);
    n_checks++;
    if (to || cap_data.size() !== 8) begin
      n_fail++;
      $display("FAIL n8_first_beats got %0d (timeout %0d) want 8", cap_data.size(), to);
    end
    for (int k = 0; k < cap_data.size() && k < 8; k++) begin
      n_checks++;
      if ({cap_data[k], cap_row[k], cap_last[k]} !== {8'h00, exp8[k], 4'(k), (k == 7)}) begin
        n_fail++;
        $display("FAIL n8_first_beat[%0d] got %h want %h", k,
                 {cap_data[k], cap_row[k], cap_last[k]}, {8'h00, exp8[k], 4'(k), (k == 7)});
      end
    end
    n_checks++;
    if ({done[4], cnt[4]} !== {1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL n8_first_final got done=%b count=%0d want 1/1", done[4], cnt[4]);
    end
  endtask

  task automatic test_small_boards();
    bit to;
    int sb;
    do_start(1, 1'b1);
    capture_run(1, 1'b0, 1'b0, -1, 2000, to, sb);
    n_checks++;
    if (to || cap_data.size() !== 0 || cnt[1] !== 16'd0 || done[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL n3_run got beats=%0d count=%0d done=%b to=%0d want 0/0/1/0",
               cap_data.size(), cnt[1], done[1], to);
    end
    do_start(0, 1'b0);
    capture_run(0, 1'b0, 1'b0, -1, 200, to, sb);
    n_checks++;
    if (to || cap_data.size() !== 1) begin
      n_fail++;
      $display("FAIL n1_beats got %0d (timeout %0d) want 1", cap_data.size(), to);
    end else begin
      n_checks++;
      if ({cap_data[0], cap_row[0], cap_last[0]} !== {16'h0001, 4'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL n1_beat got %h want %h", {cap_data[0], cap_row[0], cap_last[0]},
                 {16'h0001, 4'h0, 1'b1});
      end
    end
    n_checks++;
    if (cnt[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL n1_count got %0d want 1", cnt[0]);
    end
  endtask

  task automatic test_restart_n6();
    bit to;
    int sb;
    build_model(6);
    for (int run = 0; run < 2; run++) begin
      do_start(3, 1'b1);
      n_checks++;
      if ({busy[3], cnt[3]} !== {1'b1, 16'd0}) begin
        n_fail++;
        $display("FAIL n6_start[%0d] got busy=%b count=%0d want 1/0", run, busy[3], cnt[3]);
      end
      // Second run also pulses start mid-search and scrambles find_all.
      capture_run(3, run == 0, run == 1, (run == 1) ? 20 : -1, 20000, to, sb);
      n_checks++;
      if (to || sb != 0 || cap_data.size() !== model_sols.size() * 6) begin
        n_fail++;
        $display("FAIL n6_run[%0d] got beats=%0d stalls=%0d to=%0d want %0d/0/0", run,
                 cap_data.size(), sb, to, model_sols.size() * 6);
      end
      for (int k = 0; k < cap_data.size() && k < model_sols.size() * 6; k++) begin
        n_checks++;
        if ({cap_data[k], cap_row[k], cap_last[k]} !== exp_beat(k, 6)) begin
          n_fail++;
          $display("FAIL n6_beat[%0d][%0d] got %h want %h", run, k,
                   {cap_data[k], cap_row[k], cap_last[k]}, exp_beat(k, 6));
        end
      end
      n_checks++;
      if ({done[3], cnt[3]} !== {1'b1, 16'd4}) begin
        n_fail++;
        $display("FAIL n6_final[%0d] got done=%b count=%0d want 1/4", run, done[3], cnt[3]);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    bit to;
    int sb;
    int cyc;
    build_model(8);
    do_start(4, 1'b1);
    sol_ready = 1'b1;
    cyc = 0;
    while (!(valid[4] && row[4] == 4'd3) && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc >= 5000) begin n_fail++; $display("FAIL emit_beat3_reach got timeout want beat 3"); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy[4], done[4], valid[4], last[4], data[4], row[4], cnt[4]} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_mid_emit got %h want 0",
               {busy[4], done[4], valid[4], last[4], data[4], row[4], cnt[4]});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_start(4, 1'b1);
    capture_run(4, 1'b1, 1'b0, -1, 150000, to, sb);
    n_checks++;
    if (to || sb != 0) begin
      n_fail++;
      $display("FAIL n8_all_run got stalls=%0d to=%0d want 0/0", sb, to);
    end
    n_checks++;
    if (cap_data.size() !== 92 * 8) begin
      n_fail++;
      $display("FAIL n8_all_beats got %0d want %0d", cap_data.size(), 92 * 8);
    end
    for (int k = 0; k < cap_data.size() && k < model_sols.size() * 8; k++) begin
      n_checks++;
      if ({cap_data[k], cap_row[k], cap_last[k]} !== exp_beat(k, 8)) begin
        n_fail++;
        $display("FAIL n8_all_beat[%0d] got %h want %h", k,
                 {cap_data[k], cap_row[k], cap_last[k]}, exp_beat(k, 8));
      end
    end
    n_checks++;
    if ({done[4], cnt[4]} !== {1'b1, 16'd92}) begin
      n_fail++;
      $display("FAIL n8_all_final got done=%b count=%0d want 1/92", done[4], cnt[4]);
    end
  endtask

  initial begin
    reset = 1'b1; start = '0; find_all = 1'b0; sol_ready = 1'b1;
    #2;
    test_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    test_n4_all();
    test_n8_first();
    test_small_boards();
    test_restart_n6();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got time limit reached want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/n_queen_solver.md
Name: n_queen_solver

Overview:
- Self-contained, parametrised N-queens backtracking engine: controller and datapath in one block.
- Places one queen per row, held in one-hot row registers, and checks the newest queen against earlier rows one row per cycle.
- Streams each solution out row-by-row over a valid/ready handshake and keeps a solution count.
- Successor to the fixed 8-queen datapath/controller pair. Adds configurable board size, all-solutions/first-only mode, output backpressure and counting.

Parameters:
- N, 8, board size; legal range 1..16.
- RW, $clog2(N) (minimum 1), row/column index width.
- CW, 16, solution_count width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- find_all  in  1  sampled with start; 1 = enumerate all solutions, 0 = stop after first
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  level, high in DONE until next accepted start
- sol_valid  out  1  solution beat valid
- sol_ready  in  1  consumer accepts beat when sol_valid & sol_ready
- sol_data  out  N  one-hot column of queen in row sol_row; bit c = column c
- sol_row  out  RW  row index of current beat
- sol_last  out  1  high on beat for row N-1
- solution_count  out  CW  solutions fully emitted; saturates at all-ones

Behaviour:
- Storage:
  - N one-hot row registers (all-zero = empty row), row pointer r, check pointer k, latched mode bit.
- Reset (async, any state):
  - state IDLE; all row registers zero; r=k=0.
  - busy=0, done=0, sol_valid=0, sol_data=0, sol_row=0, sol_last=0, solution_count=0.
- States: IDLE, CHECK, NEXT_COL, BACKTRACK, EMIT, DONE.
- IDLE/DONE + start:
  - clear all rows; row0=one-hot col 0; r=0; k=r-1; solution_count=0; latch find_all; go CHECK.
  - done drops and busy rises the next cycle.
- CHECK, one cycle per comparison:
  - r=0: safe immediately (1 cycle).
  - Otherwise compare row r with row k. Conflict if same column, or |r-k| == |col_r-col_k|.
  - Conflict → NEXT_COL.
  - No conflict, k>0 → k-1, stay in CHECK.
  - No conflict, k=0 (or r=0), r<N-1 → r+1, row r+1 = col 0, k=r, stay in CHECK.
  - No conflict, k=0 (or r=0), r=N-1 → EMIT with sol_row=0.
- NEXT_COL:
  - Shift row r one column toward MSB.
  - Bit N-1 shifted out (row exhausted) → BACKTRACK.
  - Otherwise → CHECK with k=r-1.
- BACKTRACK:
  - Clear row r.
  - r=0 → DONE (search exhausted).
  - Otherwise r-1 → NEXT_COL.
- EMIT:
  - sol_valid=1; sol_data=row[sol_row]; sol_last=(sol_row==N-1).
  - Outputs hold stable while sol_ready=0 (no change while valid and not accepted).
  - On handshake, sol_row increments.
  - On last handshake:
    - solution_count += 1 (saturating).
    - Mode first-only → DONE; mode all → NEXT_COL on row N-1.
  - sol_valid falls the cycle after the last accept.
- DONE: busy=0, done=1, rows retain last board; solution_count holds final value.
- Boundary rules:
  - start while busy: ignored.
  - N=1: one solution (row0=1'b1), then DONE.
  - N=2,3: DONE with solution_count=0 and no beats.
  - find_all changes mid-search: no effect, mode latched at start.
  - reset asserted mid-EMIT: sol_valid drops immediately (async); no partial count.
- Width rules:
  - Row-distance arithmetic in RW+1 bits, unsigned absolute difference.
  - Column index from one-hot by priority encode; empty row never compared.

Test Plan:
- N=4, find_all=1, sol_ready=1 → 2 solutions. Beats 4'b0010,4'b1000,4'b0001,4'b0100, then 4'b0100,4'b0001,4'b1000,4'b0010; sol_last on 4th and 8th beats; done, solution_count=2.
- N=8, find_all=0 → one solution, columns 0,4,7,5,2,6,1,3 (sol_data 8'h01,8'h10,8'h80,8'h20,8'h04,8'h40,8'h02,8'h08); done, solution_count=1.
- N=8, find_all=1, sol_ready random 50% → 92 solutions; sol_data/sol_row stable whenever valid & !ready; solution_count=92.
- N=3 and N=1 → N=3: done, count 0, sol_valid never high. N=1: single beat 1'b1 with sol_last=1, count 1.
- N=6 run to done, then second start without reset → count restarts and ends at 4; start pulsed mid-search ignored.
- N=8, assert reset during EMIT beat 3 → all outputs reset values the same cycle; a following start produces the full 92-solution run.
